button_conditioner: RTL and testbench

Multi-channel front end for the board push-buttons: synchronises each raw button to `clk`, debounces it with a per-channel stable-count filter, and emits a clean level plus one-cycle press/release pulses. It sits directly upstream of the run/step/stop control FSM, which consumes only the `press` pulses and `level` outputs. All channels share one parameter set and run independently.

---
 rtl/button_conditioner.sv | 115 +++++++++++
 tb/tb_button_conditioner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel push-button synchroniser, debouncer and press/release pulse generator
// Define BUTTON_REPEAT_EN for auto-repeat press pulses; the release output is release_pulse because release is a reserved word.
module button_conditioner #(
  parameter int N_BUTTONS       = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_BUTTONS-1:0] button,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] press,
  output logic [N_BUTTONS-1:0] release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 1 of the state encoding is the debounced level itself.
  localparam logic [1:0] RELEASED     = 2'b00;
  localparam logic [1:0] PRESS_PEND   = 2'b01;
  localparam logic [1:0] PRESSED      = 2'b10;
  localparam logic [1:0] RELEASE_PEND = 2'b11;

`ifdef BUTTON_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
`endif

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    logic [1:0]       sync_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;
    logic             release_q;
    logic             s;
    logic             mismatch;
    logic             terminal;
    logic             rise;
    logic             fall;
    logic             rpt_fire;

    assign s        = sync_q[1];
    assign mismatch = s ^ state_q[1];
    assign terminal = mismatch && (cnt_q == DEB_TERM);
    assign rise     = terminal && !state_q[1];
    assign fall     = terminal && state_q[1];

    always_comb begin
      state_d = state_q;
      case (state_q)
        RELEASED:     if (s) state_d = terminal ? PRESSED : PRESS_PEND;
        PRESS_PEND:   if (!s) state_d = RELEASED;
                      else if (terminal) state_d = PRESSED;
        PRESSED:      if (!s) state_d = terminal ? RELEASED : RELEASE_PEND;
        RELEASE_PEND: if (s) state_d = PRESSED;
                      else if (terminal) state_d = RELEASED;
      endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync_q    <= 2'b00;
        state_q   <= RELEASED;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[0], button[i]};
        state_q   <= state_d;
        cnt_q     <= (mismatch && !terminal) ? cnt_q + CNT_W'(1) : '0;
        press_q   <= rise || rpt_fire;
        release_q <= fall;
      end
    end

`ifdef BUTTON_REPEAT_EN
    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_limit;
    logic             rpt_periodic_q;

    // First interval is REPEAT_DELAY, every later one REPEAT_PERIOD; a release edge wins.
    assign rpt_limit = rpt_periodic_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
    assign rpt_fire  = state_q[1] && !fall && (rpt_cnt_q == rpt_limit);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rpt_cnt_q      <= '0;
        rpt_periodic_q <= 1'b0;
      end else if (!state_q[1]) begin
        rpt_cnt_q      <= '0;
        rpt_periodic_q <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt_q      <= '0;
        rpt_periodic_q <= 1'b1;
      end else begin
        rpt_cnt_q      <= rpt_cnt_q + RPT_W'(1);
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign level[i]         = state_q[1];
    assign press[i]         = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

  localparam int N = 5;
`ifdef BUTTON_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] button;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  int           vectors = 0;
  int           miscompares = 0;
  logic [N-1:0] exp_press;
  logic [N-1:0] exp_level;
  logic [N-1:0] exp_rel;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .button       (button),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b1;
    button = 5'b11111;
    #2;
    resetn = 1'b0;

    // Reset held with every button down: outputs stay quiet.
    tick(1);
    check("rst_level", level, 5'b00000);
    check("rst_press", press, 5'b00000);
    check("rst_release", release_pulse, 5'b00000);
    tick(2);
    check("rst_level_hold", level, 5'b00000);
    check("rst_press_hold", press, 5'b00000);
    resetn = 1'b1;
    tick(5);
    check("postrst_level_e5", level, 5'b00000);
    check("postrst_press_e5", press, 5'b00000);
    tick(1);
    check("postrst_level_e6", level, 5'b11111);
    check("postrst_press_e6", press, 5'b11111);
    tick(1);
    check("postrst_press_e7", press, 5'b00000);
    check("postrst_level_e7", level, 5'b11111);
    button = 5'b00000;
    tick(5);
    check("allrel_level_pre", level, 5'b11111);
    check("allrel_rel_pre", release_pulse, 5'b00000);
    tick(1);
    check("allrel_rel", release_pulse, 5'b11111);
    check("allrel_level", level, 5'b00000);
    check("allrel_press", press, 5'b00000);
    tick(1);
    check("allrel_rel_end", release_pulse, 5'b00000);

    // Clean press and release on channel 0.
    button = 5'b00001;
    tick(5);
    check("clean_press_k4", press, 5'b00000);
    check("clean_level_k4", level, 5'b00000);
    tick(1);
    check("clean_press_k5", press, 5'b00001);
    check("clean_level_k5", level, 5'b00001);
    tick(1);
    check("clean_press_k6", press, 5'b00000);
    tick(13);
    button = 5'b00000;
    tick(5);
    check("clean_rel_pre", release_pulse, 5'b00000);
    check("clean_level_pre", level, 5'b00001);
    tick(1);
    check("clean_rel", release_pulse, 5'b00001);
    check("clean_rel_level", level, 5'b00000);
    check("clean_rel_press", press, 5'b00000);
    tick(1);
    check("clean_rel_end", release_pulse, 5'b00000);

    // Glitch on channel 2: 3 high, 1 low, then held high.
    button = 5'b00100;
    tick(3);
    check("glitch_press_a", press, 5'b00000);
    button = 5'b00000;
    tick(1);
    check("glitch_level_b", level, 5'b00000);
    button = 5'b00100;
    tick(5);
    check("glitch_press_c", press, 5'b00000);
    check("glitch_level_c", level, 5'b00000);
    tick(1);
    check("glitch_press_d", press, 5'b00100);
    check("glitch_level_d", level, 5'b00100);
    tick(1);
    check("glitch_press_e", press, 5'b00000);
    button = 5'b00000;
    tick(6);
    check("glitch_rel", release_pulse, 5'b00100);
    check("glitch_rel_level", level, 5'b00000);

    // Channels 1 and 3 together.
    button = 5'b01010;
    tick(5);
    check("simul_press_pre", press, 5'b00000);
    tick(1);
    check("simul_press", press, 5'b01010);
    check("simul_level", level, 5'b01010);
    check("simul_rel", release_pulse, 5'b00000);
    tick(1);
    check("simul_press_end", press, 5'b00000);
    button = 5'b00000;
    tick(6);
    check("simul_release", release_pulse, 5'b01010);
    check("simul_rel_level", level, 5'b00000);

    // Channel 4 held: repeats at +10, +13, ... ; release lands on a repeat slot.
    button = 5'b10000;
    tick(6);
    check("rpt_press_p0", press, 5'b10000);
    for (int i = 1; i <= 38; i++) begin
      tick(1);
      exp_press = (REPEAT_ON && i >= 10 && i < 37 && (i - 10) % 3 == 0) ? 5'b10000 : 5'b00000;
      exp_level = (i < 37) ? 5'b10000 : 5'b00000;
      exp_rel   = (i == 37) ? 5'b10000 : 5'b00000;
      check($sformatf("rpt_press_p%0d", i), press, exp_press);
      check($sformatf("rpt_level_p%0d", i), level, exp_level);
      check($sformatf("rpt_rel_p%0d", i), release_pulse, exp_rel);
      if (i == 31) button = 5'b00000;
    end

    // Reset while channel 0 is pending and channel 3 is pressed.
    button = 5'b01000;
    tick(6);
    check("midrst_level_ch3", level, 5'b01000);
    button = 5'b01001;
    tick(4);
    check("midrst_level_pend", level, 5'b01000);
    resetn = 1'b0;
    #1;
    check("midrst_level_clr", level, 5'b00000);
    check("midrst_press_clr", press, 5'b00000);
    tick(2);
    check("midrst_level_hold", level, 5'b00000);
    resetn = 1'b1;
    tick(5);
    check("midrst_press_e5", press, 5'b00000);
    check("midrst_level_e5", level, 5'b00000);
    tick(1);
    check("midrst_press_e6", press, 5'b01001);
    check("midrst_level_e6", level, 5'b01001);
    tick(1);
    check("midrst_press_e7", press, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
